// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels.
// Also used by the receiver, so keep the line-level constants stable.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered level.
// Head is visible the same cycle it becomes non-empty; pop takes effect on the edge.
// A push while full and a pop while empty are ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers differ only in the wrap bit when full, so the difference is the level.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queues bytes in a FIFO and serialises start/data(LSB first)/stop bits.
// Each bit starts one clk after a baud_tick edge; first start bit waits for the next tick.
// tx_ready drops when the FIFO is full; a push into a full FIFO is refused.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    import uart_pkg::*;

    localparam int              CW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    uart_tx_state_t       state;
    logic [DATA_BITS-1:0] shift;
    logic [CW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 tx_q;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] head;

    assign push     = tx_valid && tx_ready;
    assign tx_ready = !full;
    assign tx       = tx_q;
    assign busy     = (state != IDLE) || (fifo_level != '0);

    // Emptiness is the registered view, so a byte pushed on this edge is not popped on it.
    always_comb begin
        pop = 1'b0;
        if (baud_tick && !empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == STOP && stop_cnt == STOP_LAST)
                pop = 1'b1;
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .res       (res),
        .push      (push),
        .push_data (tx_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            tx_q     <= UART_IDLE_LEVEL;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= head;
                        tx_q  <= UART_START_LEVEL;
                        state <= START;
                    end
                end
                START: begin
                    tx_q    <= shift[0];
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        tx_q     <= UART_IDLE_LEVEL;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end else begin
                        shift   <= shift >> 1;
                        tx_q    <= shift[1];
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (stop_cnt != STOP_LAST) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end else if (pop) begin
                        shift <= head;
                        tx_q  <= UART_START_LEVEL;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises bytes into 8N1-style frames on a single TX line, advancing one bit per baud tick. It sits directly downstream of the baud clock generator, consuming its one-cycle `baud_tick` pulse. Bytes enter from the bus side through a valid/ready handshake into a small internal FIFO so the CPU can queue several bytes without waiting for each frame.

## Interface
- `DATA_BITS`, 8: payload bits per frame, LSB first; legal range 5–8.
- `STOP_BITS`, 1: stop bits per frame; legal values 1–2.
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of two, at least 2.
- `clk` in 1: system clock; the only clock in the block.
- `res` in 1: reset, synchronous and active-high.
- `baud_tick` in 1: one-`clk`-cycle pulse per bit period, from the baud generator.
- `tx_data` in `DATA_BITS`: byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept a byte.
- `tx` out 1: serial line; idle high.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: number of queued bytes.

## Operation
- Reset, sampled on a `clk` edge with `res`=1, produces these values after that edge: `tx`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0, state IDLE, FIFO pointers 0. Reset takes priority over every other input.
- **Push:** a byte is accepted on any edge where `tx_valid` && `tx_ready`.
  - `tx_ready` = !full, derived from the registered level. A push while full is refused, even if a pop happens in the same cycle.
- **Pop:** removes the head entry into the shift register. It occurs only on a state transition that starts a frame.
- **Simultaneous push and pop:** when not full, `fifo_level` is unchanged and both operations take effect.
- **FSM states:** IDLE, START, DATA, STOP. All transitions occur only on edges where `baud_tick`=1; otherwise every state holds.
  - IDLE: `tx`=1. On a tick with the FIFO non-empty: pop, `tx`<=0, go to START.
  - START: on a tick, `tx`<=shift[0], `bit_cnt`<=0, go to DATA.
  - DATA: on a tick with `bit_cnt` < `DATA_BITS`-1: shift right, `tx`<=next bit, `bit_cnt`++. On a tick with `bit_cnt` = `DATA_BITS`-1: `tx`<=1, `stop_cnt`<=0, go to STOP.
  - STOP: on a tick with `stop_cnt` < `STOP_BITS`-1: `stop_cnt`++. On the final stop tick:
    - FIFO non-empty: pop, `tx`<=0, go to START. Frames run back-to-back with no idle bit.
    - FIFO empty: `tx` stays 1, go to IDLE.
- `busy` = (state != IDLE) || (`fifo_level` != 0).
- If a byte is pushed into an empty FIFO on the same edge as an IDLE tick, it is not popped on that edge; its frame starts on the next tick.
- Reset mid-frame aborts the frame. `tx` returns high on the following edge and queued bytes are discarded.

## Timing
- `tx` is driven directly from a flop, with no combinational path from inputs.
- Each bit lasts exactly one tick period. Bit edges appear one `clk` after the tick edge.
- Frame length is 1 + `DATA_BITS` + `STOP_BITS` tick periods.
- Latency from IDLE with the FIFO non-empty to the start bit: the start bit appears at the first tick edge, i.e. 0 to 1 tick period of wait.
- `tx_ready` deasserts on the edge after the push that fills the FIFO, and reasserts on the edge after a pop from full.
- `fifo_level` updates on the edge of the push or pop.

## Structure
- A shared package `uart_pkg` holds:
  - the `uart_tx_state_t` enum {IDLE, START, DATA, STOP};
  - the constants `UART_IDLE_LEVEL`=1'b1 and `UART_START_LEVEL`=1'b0 (reused by the future `uart_rx`).
- One sub-module, `uart_fifo`: a synchronous FIFO with the same `clk`/`res`, push/pop, full/empty and level outputs. Pointers carry one extra wrap bit.
- The FSM, shift register, `bit_cnt` and `stop_cnt` live in `uart_tx`.

## Test plan
- Reset mid-frame: push 0xFF, apply `res` after 3 ticks → on the next edge `tx`=1, `busy`=0, `fifo_level`=0; a later push sends a clean frame.
- Single byte: push 0x55 in IDLE with ticks every 16 clk → `tx` sequence per tick is 0, 1,0,1,0,1,0,1,0, 1; then IDLE and `busy`=0 after the stop bit.
- Back-to-back: push 0x00 and 0xFF → the stop bit of the first frame is followed directly by the start bit of the second (20 bit periods total, no extra high bit).
- FIFO full: with ticks stopped, push 5 bytes with `tx_valid` held → 4 accepted, `tx_ready`=0, `fifo_level`=4; the 5th byte is accepted only after the first pop.
- Push on tick edge: while IDLE and empty, push 0xA5 on the same edge as a tick → no start bit on that tick; the start bit begins on the next tick.
- Parameter sweep: `DATA_BITS`=7, `STOP_BITS`=2, byte 0x41 → start, 1,0,0,0,0,0,1, then 1, 1 (10 bit periods).
